// File: rtl/cnn_mem_bank.sv
// Multi-bank CNN storage peripheral on an Avalon-MM slave port.
// The host fills banks through an auto-incrementing DATA port and reads them
// back; a START command streams one bank to the CNN engine over valid/ready.
module cnn_mem_bank #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 256,
    parameter int NUM_BANKS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [1:0]        address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] stream_data,
    output logic              stream_valid,
    output logic              stream_last,
    input  logic              stream_ready
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BANK_W = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

    // One storage array per bank; the host write port and the stream read
    // port operate independently.
    logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

    state_t            state;
    logic [PTR_W-1:0]  hptr;
    logic [BANK_W-1:0] hbank;
    logic [PTR_W-1:0]  sptr;
    logic [PTR_W-1:0]  sptr_next;
    logic [PTR_W-1:0]  slen_m1;     // stream length minus one; hptr==0 wraps to DEPTH-1
    logic [BANK_W-1:0] sbank;
    logic              busy;
    logic              done_f;
    logic              wrap_f;
    logic              err_f;

    // Decoded host accesses
    logic              ctrl_wr;
    logic              stat_rd;
    logic              data_rd;
    logic              data_wr_req;
    logic              data_wr;
    logic              ptr_wr;
    logic              data_step;
    logic              bank_hit;
    logic              start_req;
    logic              start_go;
    logic              err_set;
    logic              wrap_set;
    logic              done_set;
    logic              handshake;
    logic              last_word;
    logic [BANK_W-1:0] ctrl_bank;

    assign ctrl_bank   = writedata[2 +: BANK_W];
    assign ctrl_wr     = chipselect && write && (address == 2'd0);
    assign stat_rd     = chipselect && read  && (address == 2'd1);
    assign data_rd     = chipselect && read  && (address == 2'd2);
    assign data_wr_req = chipselect && write && (address == 2'd2);
    assign ptr_wr      = chipselect && write && (address == 2'd3);

    // A write into the bank currently being streamed would corrupt the stream.
    assign bank_hit    = busy && (hbank == sbank);
    assign data_wr     = data_wr_req && !bank_hit;
    assign data_step   = data_rd || data_wr;

    assign start_req   = ctrl_wr && writedata[0];
    assign start_go    = start_req && !busy;

    assign handshake   = stream_valid && stream_ready;
    assign last_word   = (sptr == slen_m1);
    assign sptr_next   = sptr + PTR_W'(1);

    assign err_set     = (start_req && busy) || (data_wr_req && bank_hit);
    assign wrap_set    = data_step && (hptr == PTR_W'(DEPTH - 1));
    assign done_set    = (state == STREAM) && handshake && last_word;

    // Stream FSM: fetch word 0 in PRIME, then one word per accepted handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: every register here uses <= so all of them update from the
            // same pre-edge values, regardless of statement order.
            state        <= IDLE;
            sptr         <= '0;
            slen_m1      <= '0;
            sbank        <= '0;
            busy         <= 1'b0;
            stream_data  <= '0;
            stream_valid <= 1'b0;
            stream_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_go) begin
                        state   <= PRIME;
                        sptr    <= '0;
                        slen_m1 <= hptr - PTR_W'(1);
                        sbank   <= ctrl_bank;
                        busy    <= 1'b1;
                    end
                end
                PRIME: begin
                    stream_data  <= mem[sbank][sptr];
                    stream_valid <= 1'b1;
                    stream_last  <= last_word;
                    state        <= STREAM;
                end
                STREAM: begin
                    if (handshake) begin
                        if (last_word) begin
                            stream_valid <= 1'b0;
                            stream_last  <= 1'b0;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            sptr        <= sptr_next;
                            stream_data <= mem[sbank][sptr_next];
                            stream_last <= (sptr_next == slen_m1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Host register side: pointer, bank select, read data and sticky flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            readdata <= '0;
            hptr     <= '0;
            hbank    <= '0;
            done_f   <= 1'b0;
            wrap_f   <= 1'b0;
            err_f    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                hbank <= ctrl_bank;
                if (writedata[1]) begin
                    hptr <= '0;
                end
            end else if (ptr_wr) begin
                hptr <= writedata[PTR_W-1:0];
            end else if (data_step) begin
                hptr <= hptr + PTR_W'(1);
            end

            if (chipselect && read) begin
                case (address)
                    2'd0:    readdata <= '0;
                    2'd1:    readdata <= {{(DATA_W-4){1'b0}}, err_f, wrap_f, done_f, busy};
                    2'd2:    readdata <= mem[hbank][hptr];
                    default: readdata <= DATA_W'(hptr);
                endcase
            end

            // A set event in the same cycle as a STATUS read wins over the clear.
            done_f <= done_set || (done_f && !stat_rd);
            wrap_f <= wrap_set || (wrap_f && !stat_rd);
            err_f  <= err_set  || (err_f  && !stat_rd);
        end
    end

    // Host write port into the selected bank.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset, so contents survive a reset
        // and the array can map onto block RAM.
        if (data_wr) begin
            mem[hbank][hptr] <= writedata;
        end
    end

endmodule

// File: tb/tb_cnn_mem_bank.sv
// Directed self-checking bench for cnn_mem_bank (DATA_W=8, DEPTH=256, 2 banks).
module tb_cnn_mem_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       chipselect = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [1:0] address = 2'd0;
    logic [7:0] writedata = 8'd0;
    logic [7:0] readdata;
    logic [7:0] stream_data;
    logic       stream_valid;
    logic       stream_last;
    logic       stream_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cap_data [0:299];
    logic       cap_last [0:299];
    int         n_cap;
    int         stall_bad;
    logic [7:0] rd;
    bit         found;

    cnn_mem_bank #(
        .DATA_W   (8),
        .DEPTH    (256),
        .NUM_BANKS(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .stream_data (stream_data),
        .stream_valid(stream_valid),
        .stream_last (stream_last),
        .stream_ready(stream_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
    endtask

    // Drives stream_ready and records accepted words until the last one is
    // accepted or the cycle budget runs out. With use_pat, ready follows pat
    // (bit 0 first) on each cycle that stream_valid is high.
    task automatic collect(input int budget, input logic [4:0] pat, input bit use_pat);
        int         vi;
        bit         held;
        bit         fin;
        logic [7:0] held_data;
        vi        = 0;
        held      = 1'b0;
        fin       = 1'b0;
        held_data = 8'd0;
        n_cap     = 0;
        stall_bad = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            if (held && stream_data !== held_data) stall_bad++;
            if (stream_valid) begin
                stream_ready = use_pat ? pat[vi % 5] : 1'b1;
                vi++;
            end else begin
                stream_ready = 1'b1;
            end
            #1;
            if (stream_valid) begin
                if (stream_ready) begin
                    if (n_cap < 300) begin
                        cap_data[n_cap] = stream_data;
                        cap_last[n_cap] = stream_last;
                    end
                    n_cap++;
                    held = 1'b0;
                    if (stream_last) fin = 1'b1;
                end else begin
                    held      = 1'b1;
                    held_data = stream_data;
                end
            end
        end
    endtask

    // Expected word i is (a + m*i) mod 256; stream_last only on the final word.
    task automatic check_stream(input string tag, input int n_exp, input int a, input int m);
        int bad_data;
        int bad_last;
        bad_data = 0;
        bad_last = 0;
        check({tag, "_count"}, 32'(n_cap), 32'(n_exp));
        for (int i = 0; i < n_cap && i < 300; i++) begin
            if (cap_data[i] !== 8'(a + m * i)) bad_data++;
            if (cap_last[i] !== (i == n_exp - 1)) bad_last++;
        end
        check({tag, "_data_errs"}, 32'(bad_data), 0);
        check({tag, "_last_errs"}, 32'(bad_last), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", 32'(readdata), 0);
        check("rst_valid",    32'(stream_valid), 0);
        check("rst_last",     32'(stream_last), 0);
        check("rst_sdata",    32'(stream_data), 0);
        @(negedge clk);
        reset = 1'b1;
        bus_read(2'd1, rd); check("rst_status", 32'(rd), 'h00);
        bus_read(2'd3, rd); check("rst_ptr",    32'(rd), 'h00);

        // Load bank 1 and read it back
        bus_write(2'd0, 8'h04);
        bus_write(2'd2, 8'h11);
        bus_write(2'd2, 8'h22);
        bus_write(2'd2, 8'h33);
        bus_read(2'd3, rd); check("t1_ptr", 32'(rd), 3);
        bus_write(2'd3, 8'h00);
        bus_read(2'd2, rd); check("t1_rd0", 32'(rd), 'h11);
        bus_read(2'd2, rd); check("t1_rd1", 32'(rd), 'h22);
        bus_read(2'd2, rd); check("t1_rd2", 32'(rd), 'h33);

        // Stream 3 words from bank 1 with ready held high
        stream_ready = 1'b0;
        bus_write(2'd0, 8'h05);
        bus_read(2'd1, rd); check("t2_status_busy", 32'(rd), 'h01);
        collect(20, 5'b00000, 1'b0);
        check_stream("t2", 3, 'h11, 'h11);
        bus_read(2'd1, rd); check("t2_status_done",  32'(rd), 'h02);
        bus_read(2'd1, rd); check("t2_status_clear", 32'(rd), 'h00);
        check("t2_valid_low", 32'(stream_valid), 0);

        // Same stream with ready toggling 1,0,0,1,1
        bus_write(2'd0, 8'h05);
        collect(40, 5'b11001, 1'b1);
        check_stream("t3", 3, 'h11, 'h11);
        check("t3_stall_stable", 32'(stall_bad), 0);
        bus_read(2'd1, rd); check("t3_status", 32'(rd), 'h02);

        // Full-depth fill of bank 0 with WRAP, then a 256-word stream
        bus_write(2'd0, 8'h00);
        bus_write(2'd3, 8'h00);
        for (int i = 0; i < 256; i++) bus_write(2'd2, 8'(i));
        bus_read(2'd3, rd); check("t4_ptr_wrapped", 32'(rd), 0);
        bus_read(2'd1, rd); check("t4_status_wrap", 32'(rd), 'h04);
        bus_write(2'd0, 8'h01);
        collect(600, 5'b00000, 1'b0);
        check_stream("t4", 256, 0, 1);
        bus_read(2'd1, rd); check("t4_status_done", 32'(rd), 'h02);

        // START while busy and a write into the streaming bank
        bus_write(2'd0, 8'h04);
        bus_write(2'd3, 8'h03);
        bus_write(2'd2, 8'h44);
        bus_write(2'd3, 8'h03);
        stream_ready = 1'b0;
        bus_write(2'd0, 8'h05);
        bus_write(2'd0, 8'h05);
        bus_write(2'd2, 8'hEE);
        bus_read(2'd3, rd); check("t5_ptr_unchanged", 32'(rd), 3);
        bus_write(2'd0, 8'h00);
        bus_write(2'd3, 8'h05);
        bus_write(2'd2, 8'hAB);
        collect(20, 5'b00000, 1'b0);
        check_stream("t5", 3, 'h11, 'h11);
        bus_read(2'd1, rd); check("t5_status_err", 32'(rd), 'h0A);
        bus_write(2'd0, 8'h04);
        bus_write(2'd3, 8'h03);
        bus_read(2'd2, rd); check("t5_dropped_word", 32'(rd), 'h44);
        bus_write(2'd0, 8'h00);
        bus_write(2'd3, 8'h05);
        bus_read(2'd2, rd); check("t5_other_bank", 32'(rd), 'hAB);

        // Reset in the middle of a 10-word stream
        bus_write(2'd0, 8'h04);
        bus_write(2'd3, 8'h00);
        for (int i = 0; i < 10; i++) bus_write(2'd2, 8'(8'hA0 + i));
        stream_ready = 1'b1;
        bus_write(2'd0, 8'h05);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            #1;
            if (stream_valid && stream_data == 8'hA2) found = 1'b1;
        end
        check("t6_word2_seen", 32'(found), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("t6_valid_low", 32'(stream_valid), 0);
        check("t6_last_low",  32'(stream_last), 0);
        check("t6_sdata_clr", 32'(stream_data), 0);
        check("t6_readdata",  32'(readdata), 0);
        bus_read(2'd1, rd); check("t6_status", 32'(rd), 'h00);
        bus_read(2'd3, rd); check("t6_ptr",    32'(rd), 0);
        check("t6_valid_still_low", 32'(stream_valid), 0);
        bus_write(2'd0, 8'h04);
        bus_write(2'd3, 8'h00);
        bus_read(2'd2, rd); check("t6_mem0", 32'(rd), 'hA0);
        bus_write(2'd3, 8'h09);
        bus_read(2'd2, rd); check("t6_mem9", 32'(rd), 'hA9);
        bus_write(2'd0, 8'h00);
        bus_write(2'd3, 8'h05);
        bus_read(2'd2, rd); check("t6_bank0", 32'(rd), 'hAB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
